// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter: widths, FSM encoding
// and the round-robin pointer wrap helper.
package regfile_pkg;

    localparam int         AW       = 5;
    localparam int         DW       = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Next requester index with explicit wrap, so non-power-of-two NREQ never yields idx >= n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int n);
        return (int'(idx) >= n - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/regfile_wport_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after ptr, wrapping
// modulo NREQ. Returns one-hot grant plus binary index.
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] valid,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      idx,
    output logic            found
);

    logic [2*NREQ-1:0] dbl_s;
    int                off_s;
    int                sum_s;

    // Low NREQ bits are valid rotated so that bit 0 is the requester at ptr; the upper
    // copy only repeats bits already present lower down, so scanning it is harmless.
    assign dbl_s = {valid, valid} >> ptr;

    // Lowest set bit of the rotated vector is the winner.
    always_comb begin
        off_s = 0;
        found = 1'b0;
        for (int k = 2*NREQ-1; k >= 0; k--) begin
            if (dbl_s[k]) begin
                off_s = k;
                found = 1'b1;
            end else begin
                off_s = off_s;
            end
        end
        sum_s = int'(ptr) + off_s;
        idx   = 3'((sum_s >= NREQ) ? (sum_s - NREQ) : sum_s);
        if (found) begin
            grant = {{(NREQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter with lockable bursts sharing the single register-file write port.
// Outputs WE/rW/W are registered and drive the register file directly.
module regfile_wport_arbiter #(
    parameter int NREQ     = 3,
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               WE,
    output logic [AW-1:0]      rW,
    output logic [DW-1:0]      W,
    output logic [2:0]         lock_owner,
    output logic               locked,
    output logic               lock_abort
);

    import regfile_pkg::*;

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(LOCK_MAX);

    state_t           state_r, state_n;
    logic [2:0]       rr_ptr_r, rr_ptr_n;
    logic [2:0]       lock_owner_r, lock_owner_n;
    logic [CNT_W-1:0] lock_cnt_r, lock_cnt_n;
    logic             lock_abort_r, lock_abort_n;

    logic [NREQ-1:0]  pick_grant_s;
    logic [2:0]       pick_idx_s;
    logic             pick_found_s;
    logic [NREQ-1:0]  owner_onehot_s;
    logic             acc_s;
    logic             acc_lock_s;
    logic [AW-1:0]    acc_addr_s;
    logic [DW-1:0]    acc_data_s;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign owner_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << lock_owner_r;

    // Ready generation: held low during reset, owner-only while locked, round-robin otherwise.
    always_comb begin
        req_ready = '0;
        if (rst) begin
            req_ready = '0;
        end else if (state_r == ST_LOCKED) begin
            req_ready = owner_onehot_s & req_valid;
        end else begin
            req_ready = pick_grant_s;
        end
    end

    assign acc_s      = |(req_valid & req_ready);
    assign acc_lock_s = |(req_lock & req_ready);

    // Packed-slice mux of the accepted beat; zero when nothing is accepted, so X on idle lanes stays out.
    always_comb begin
        acc_addr_s = '0;
        acc_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                acc_addr_s = req_addr[i*AW +: AW];
                acc_data_s = req_data[i*DW +: DW];
            end else begin
                acc_addr_s = acc_addr_s;
            end
        end
    end

    // Next-state logic for arbitration, lock tracking and timeout.
    always_comb begin
        state_n      = state_r;
        rr_ptr_n     = rr_ptr_r;
        lock_owner_n = lock_owner_r;
        lock_cnt_n   = lock_cnt_r;
        lock_abort_n = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (acc_s) begin
                    rr_ptr_n = wrap_inc(pick_idx_s, NREQ);
                    if (acc_lock_s) begin
                        state_n      = ST_LOCKED;
                        lock_owner_n = pick_idx_s;
                        lock_cnt_n   = '0;
                    end else begin
                        state_n = ST_ARB;
                    end
                end else begin
                    state_n = ST_ARB;
                end
            end
            ST_LOCKED: begin
                lock_cnt_n = (lock_cnt_r == CNT_SAT) ? lock_cnt_r : lock_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (acc_s && !acc_lock_s) begin
                    state_n  = ST_ARB;
                    rr_ptr_n = wrap_inc(lock_owner_r, NREQ);
                end else if (lock_cnt_r == CNT_TOP) begin
                    state_n      = ST_ARB;
                    rr_ptr_n     = wrap_inc(lock_owner_r, NREQ);
                    lock_abort_n = 1'b1;
                end else begin
                    state_n = ST_LOCKED;
                end
            end
            default: begin
                state_n = ST_ARB;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= 3'd0;
            lock_owner_r <= 3'd0;
            lock_cnt_r   <= '0;
            lock_abort_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            rr_ptr_r     <= rr_ptr_n;
            lock_owner_r <= lock_owner_n;
            lock_cnt_r   <= lock_cnt_n;
            lock_abort_r <= lock_abort_n;
        end
    end

    // Write-port output register; r0 beats complete the handshake but never enable a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WE <= 1'b0;
            rW <= '0;
            W  <= '0;
        end else if (acc_s) begin
            WE <= (acc_addr_s != AW'(REG_ZERO));
            rW <= acc_addr_s;
            W  <= acc_data_s;
        end else begin
            WE <= 1'b0;
        end
    end

    assign locked     = (state_r == ST_LOCKED);
    assign lock_owner = lock_owner_r;
    assign lock_abort = lock_abort_r;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomised scoreboard bench for regfile_wport_arbiter with a behavioural arbiter model
// and a 32x32 register file model fed by WE/rW/W.
module tb_regfile_wport_arbiter;

    localparam int NREQ     = 3;
    localparam int AW       = 5;
    localparam int DW       = 32;
    localparam int LOCK_MAX = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_lock = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               WE;
    logic [AW-1:0]      rW;
    logic [DW-1:0]      W;
    logic [2:0]         lock_owner;
    logic               locked;
    logic               lock_abort;

    regfile_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .WE(WE), .rW(rW), .W(W), .lock_owner(lock_owner), .locked(locked),
        .lock_abort(lock_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] rw;
        logic [DW-1:0] w;
        logic          lkd;
        int            owner;
        logic          abort;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] rf[32];
    logic [DW-1:0] golden[32];

    int            m_ptr, m_owner, m_lc, m_last_owner;
    logic [AW-1:0] m_rw;
    logic [DW-1:0] m_w;
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_owner = -1; m_lc = 0; m_last_owner = 0;
        m_rw = '0; m_w = '0; pend_we = 1'b0; pend_addr = '0; pend_data = '0;
        q.delete();
    endtask

    // Register file model: captures on the edge after WE is presented.
    always @(posedge clk) begin
        if (WE) rf[rW] <= W;
    end

    // Monitor: one expected entry per clock edge out of reset.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (q.size() == 0) begin
                check("scoreboard_underflow", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("WE", WE, mon_e.we);
                check("rW", rW, mon_e.rw);
                check("W", W, mon_e.w);
                check("locked", locked, mon_e.lkd);
                check("lock_abort", lock_abort, mon_e.abort);
                if (mon_e.lkd) check("lock_owner", lock_owner, 64'(mon_e.owner));
            end
        end
    end

    // Called at a negedge: apply a beat set, predict from the arbitration rules, wait a cycle.
    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                         input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
        int   g;
        exp_t e;
        req_valid = v; req_lock = l; req_addr = a; req_data = d;
        #1;
        if (pend_we) golden[pend_addr] = pend_data;
        pend_we = 1'b0;
        g = -1;
        if (m_owner >= 0) begin
            if (v[m_owner]) g = m_owner;
        end else begin
            for (int k = NREQ-1; k >= 0; k--)
                if (v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
        check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        e.abort = 1'b0;
        e.we    = 1'b0;
        if (g >= 0) begin
            m_rw = a[g*AW +: AW];
            m_w  = d[g*DW +: DW];
            e.we = (m_rw != 0);
            if (e.we) begin
                pend_we = 1'b1; pend_addr = m_rw; pend_data = m_w;
            end
        end
        if (m_owner >= 0) begin
            m_lc++;
            if (g >= 0 && !l[g]) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1;
            end else if (m_lc == LOCK_MAX) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1; e.abort = 1'b1;
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NREQ;
            if (l[g]) begin
                m_owner = g; m_lc = 0; m_last_owner = g;
            end
        end
        e.lkd = (m_owner >= 0); e.owner = m_last_owner; e.rw = m_rw; e.w = m_w;
        q.push_back(e);
        @(negedge clk);
    endtask

    logic [NREQ*AW-1:0] ra;
    logic [NREQ*DW-1:0] rd;

    task automatic rand_lanes();
        for (int i = 0; i < NREQ; i++) begin
            ra[i*AW +: AW] = AW'($urandom);
            rd[i*DW +: DW] = $urandom;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin rf[i] = '0; golden[i] = '0; end
        model_reset();
        // Reset state with every requester asking.
        req_valid = '1;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 64'd0);
        check("rst_WE", WE, 64'd0);
        check("rst_rW", rW, 64'd0);
        check("rst_W", W, 64'd0);
        check("rst_locked", locked, 64'd0);
        check("rst_abort", lock_abort, 64'd0);
        rst = 1'b0;

        // Put a live write in the output register, then reset mid-cycle.
        rand_lanes(); ra[AW-1:0] = 5'd3; ra[2*AW-1:AW] = 5'd4;
        drive(3'b111, 3'b000, ra, rd);
        drive(3'b111, 3'b000, ra, rd);
        check("pre_rst_WE", WE, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_WE", WE, 64'd0);
        check("mid_rst_ready", req_ready, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin with all valid.
        for (int b = 0; b < 6; b++) begin
            rand_lanes();
            for (int i = 0; i < NREQ; i++) ra[i*AW +: AW] = AW'(1 + i + 3*b);
            drive(3'b111, 3'b000, ra, rd);
        end

        // r0 write from req1.
        rand_lanes(); ra[2*AW-1:AW] = 5'd0; rd[2*DW-1:DW] = 32'hDEADBEEF;
        drive(3'b010, 3'b000, ra, rd);

        // Locked burst from req2 while the others keep asking.
        for (int b = 0; b < 4; b++) begin
            rand_lanes(); ra[3*AW-1:2*AW] = AW'(8 + b);
            drive(3'b111, (b < 3) ? 3'b100 : 3'b000, ra, rd);
        end
        rand_lanes();
        drive(3'b111, 3'b000, ra, rd);

        // Lock by req1 then idle into timeout; req2 waits.
        rand_lanes();
        drive(3'b010, 3'b010, ra, rd);
        for (int b = 0; b < 6; b++) begin
            rand_lanes();
            drive(3'b100, 3'b000, ra, rd);
        end

        // Back-to-back stream from req0 covering r0..r31.
        for (int b = 0; b < 32; b++) begin
            rand_lanes(); ra[AW-1:0] = AW'(b);
            drive(3'b001, 3'b000, ra, rd);
        end

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rand_lanes();
            drive(NREQ'($urandom), ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0, ra, rd);
        end

        // Drain and compare register contents.
        for (int c = 0; c < LOCK_MAX + 3; c++) drive('0, '0, ra, rd);
        check("queue_drain", 64'(q.size()), 64'd0);
        for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), rf[i], golden[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
